// File: rtl/tcp_pkg.sv
// Shared types for the TCP transmit arbiter: FSM state encoding and the
// default IP header bundle width.
package tcp_pkg;
  localparam int HDR_WIDTH_DEF = 96;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: the scan starts at the requester
// after the last grant (stream 0 when no grant has been recorded yet).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_last_grant,
  output logic [N-1:0] o_grant
);
  int w_start;

  always_comb begin
    w_start = 0;
    for (int i = 0; i < N; i++)
      if (i_last_grant[i]) w_start = (i + 1) % N;
    o_grant = '0;
    // Walk distances from far to near so the nearest requester wins.
    for (int k = N - 1; k >= 0; k--)
      for (int i = 0; i < N; i++)
        if (i_req[i] && (i == (w_start + k) % N)) begin
          o_grant    = '0;
          o_grant[i] = 1'b1;
        end
  end
endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin merge of NUM_STREAMS header+payload TCP transmit streams onto one
// output. Optional payload stall abort is enabled by TCP_TX_ARB_TIMEOUT_EN.
module tcp_tx_arbiter
  import tcp_pkg::*;
#(
  parameter int NUM_STREAMS    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int HDR_WIDTH      = HDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_STREAMS-1:0]            s_hdr_valid,
  output logic [NUM_STREAMS-1:0]            s_hdr_ready,
  input  logic [NUM_STREAMS*HDR_WIDTH-1:0]  s_hdr_data,
  input  logic [NUM_STREAMS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_STREAMS-1:0]            s_axis_tvalid,
  input  logic [NUM_STREAMS-1:0]            s_axis_tlast,
  output logic [NUM_STREAMS-1:0]            s_axis_tready,
  output logic                              m_hdr_valid,
  input  logic                              m_hdr_ready,
  output logic [HDR_WIDTH-1:0]              m_hdr_data,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic [NUM_STREAMS-1:0]            o_grant
);
  localparam int IW = $clog2(NUM_STREAMS);

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_STREAMS-1:0] r_grant, r_last, w_rr_grant;
  logic [IW-1:0]          w_idx;
  logic                   w_sel_tvalid, w_sel_tlast, w_abort;

  rr_arbiter #(.N(NUM_STREAMS)) u_rr (
    .i_req        (s_hdr_valid),
    .i_last_grant (r_last),
    .o_grant      (w_rr_grant)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_STREAMS; i++)
      if (r_grant[i]) w_idx = IW'(i);
  end

  assign w_sel_tvalid = s_axis_tvalid[w_idx];
  assign w_sel_tlast  = s_axis_tlast[w_idx];
  assign o_grant      = r_grant;

`ifdef TCP_TX_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_beat_acc;

  assign w_beat_acc = (r_state == PAYLOAD) && !w_abort && w_sel_tvalid && m_axis_tready;
  assign w_abort    = (r_state == PAYLOAD) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  // Counts consecutive idle payload cycles of the owner; saturates once the abort beat is up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_tmo_cnt <= '0;
    else if (r_state != PAYLOAD)     r_tmo_cnt <= '0;
    else if (w_beat_acc)             r_tmo_cnt <= '0;
    else if (!w_abort && !w_sel_tvalid) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_hdr_ready   = '0;
    s_axis_tready = '0;
    m_hdr_valid   = 1'b0;
    m_hdr_data    = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (r_state)
      IDLE: if (|s_hdr_valid) w_state_nxt = HDR;
      HDR: begin
        m_hdr_valid = s_hdr_valid[w_idx];
        m_hdr_data  = s_hdr_data[w_idx*HDR_WIDTH +: HDR_WIDTH];
        s_hdr_ready = r_grant & {NUM_STREAMS{m_hdr_ready}};
        if (s_hdr_valid[w_idx] && m_hdr_ready) w_state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (w_abort) begin
          // Synthetic error-terminated beat; the stalled owner stays held off.
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = 1'b1;
          m_axis_tuser  = 1'b1;
          if (m_axis_tready) w_state_nxt = IDLE;
        end else begin
          m_axis_tvalid = w_sel_tvalid;
          m_axis_tdata  = s_axis_tdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tlast  = w_sel_tlast;
          s_axis_tready = r_grant & {NUM_STREAMS{m_axis_tready}};
          if (w_sel_tvalid && w_sel_tlast && m_axis_tready) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_last of zero means no history, so the search starts at stream 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant <= '0;
      r_last  <= '0;
    end else if (r_state == IDLE && w_state_nxt == HDR) begin
      r_grant <= w_rr_grant;
      r_last  <= w_rr_grant;
    end else if (r_state == PAYLOAD && w_state_nxt == IDLE) begin
      r_grant <= '0;
    end
  end
endmodule
